dp_sequencer: RTL and testbench
===============================

# dp_sequencer

Multi-cycle issue sequencer for ARM data-processing instructions; the producer side of the ALU interface. Accepts one 32-bit instruction per handshake, decodes it, fetches operands from the register file, builds the shifter operand, drives `alu_control`/operands, then commits the ALU result and NZCV. It owns the CPSR condition flags and sits between fetch/decode and the ALU/register file.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `instr_valid`  in  1  instruction offered
- `instr_ready`  out  1  sequencer can accept (IDLE only)
- `instr`  in  32  ARM instruction word
- `rf_raddr_a` / `rf_raddr_b`  out  4  Rn / Rm read addresses
- `rf_rdata_a` / `rf_rdata_b`  in  32  read data, valid one cycle after address
- `rf_we`  out  1  register write strobe; `rf_waddr` out 4; `rf_wdata` out 32
- `alu_operand_a` / `alu_operand_b`  out  32  Rn / shifter operand
- `alu_control`  out  4  opcode field `instr[24:21]`, ARM encoding (AND=0000 … MVN=1111)
- `alu_carry`  out  1  current CPSR C, for ADC/SBC/RSC
- `alu_result` in 32; `alu_nzcv` in 4; `alu_result_writeback` in 1  from ALU (combinational)
- `cpsr_nzcv`  out  4  architectural flags
- `done`  out  1  one-cycle retire pulse; `done_illegal` out 1; `done_cond_pass` out 1

## Operation
- FSM: IDLE → READ → EXEC → WB → IDLE. Handshake only in IDLE (`instr_ready`=1); `instr` latched on `instr_valid & instr_ready`.
- READ: drive `rf_raddr_a`=instr[19:16], `rf_raddr_b`=instr[3:0].
- EXEC: build operand2, drive ALU, evaluate condition instr[31:28] against `cpsr_nzcv` (all 15 ARM codes; 1111 = never pass), register result, ALU NZCV, shifter carry.
- Immediate (I=1): imm8 ROR 2·rot; shifter C = old C if rot=0, else bit 31 of result.
- Register (I=0, bit4=0): Rm shifted by imm5, type instr[6:5]. LSL#0 = Rm, C=old C. LSR#0 ≡ LSR#32: 0, C=Rm[31]. ASR#0 ≡ ASR#32: sign fill, C=Rm[31]. ROR#0 = RRX {C,Rm[31:1]}, C=Rm[0]. Otherwise C = last bit shifted out.
- Illegal: instr[27:26]≠00; I=0 with bit4=1; opcode 10xx with S=0; Rd=15 on a result-writing op. Illegal ⇒ no writes, no flag change.
- WB (legal, condition passed): `rf_we`=`alu_result_writeback`, `rf_waddr`=instr[15:12], `rf_wdata`=registered result. If S=1: arithmetic ops (SUB,RSB,ADD,ADC,SBC,RSC,CMP,CMN) load ALU NZCV; logical ops load N,Z from ALU, C from shifter, V unchanged.
- Condition fail: no write, no flag change, `done_cond_pass`=0.

## Timing
- Handshake edge = cycle 0. READ cycle 1, EXEC cycle 2, WB cycle 3 (`done`, `rf_we` high; flags update on the closing edge), IDLE with `instr_ready`=1 in cycle 4.
- Fixed 4-cycle latency regardless of illegal/condition outcome; throughput one instruction per 4 cycles.
- `done_illegal`/`done_cond_pass` valid only while `done`=1, else 0.
- Reset values: state IDLE, `instr_ready` 0 while reset low and 1 in the first cycle after release; all other outputs, including `cpsr_nzcv`, 0.
- Reset asserted mid-instruction: immediate abort, no `rf_we`, no flag update, no `done`.
- `instr_valid` outside IDLE is ignored; `instr` need not stay stable after the handshake.

## Configuration
- `DP_SEQUENCER_SHIFT_EN` defined: register-form immediate shifts (LSL/LSR/ASR/ROR/RRX) implemented as above.
- Undefined: register form is legal only with instr[11:4]=0 (operand2 = Rm, shifter C = old C); any nonzero instr[11:4] with I=0 is illegal.

## Test plan
- Reset low, then released → all outputs 0 during reset; `instr_ready`=1 in first cycle after release.
- ADDS R1,R2,#5 (0xE2921005), R2=3 → cycle 3: `rf_we`=1, `rf_waddr`=1, `rf_wdata`=8, `cpsr_nzcv`=0000 after WB.
- SUBS R0,R0,R0 with R0=7, then ADDNE R3,R3,#1 (0x12833001) → R0=0, flags 0110; second instruction `done`=1, `done_cond_pass`=0, no `rf_we`.
- MOVS R4,#0xFF000000 (0xE3B044FF) → `rf_wdata`=0xFF000000, N=1, C=1 (rot≠0), V unchanged.
- CMP with S=0 (0xE1400000) → `done_illegal`=1 at cycle 3, no `rf_we`, flags unchanged.
- Reset asserted during EXEC of ADD → no `rf_we`, no `done`; next instruction after release executes normally.

Source files
------------

// File: rtl/dp_sequencer.sv
// Multi-cycle issue sequencer for ARM data-processing instructions: decode, operand fetch,
// shifter operand, ALU drive and result/NZCV commit. Define DP_SEQUENCER_SHIFT_EN for register-form immediate shifts.
module dp_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [31:0] rf_rdata_a,
  input  logic [31:0] rf_rdata_b,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] alu_operand_a,
  output logic [31:0] alu_operand_b,
  output logic [3:0]  alu_control,
  output logic        alu_carry,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_nzcv,
  input  logic        alu_result_writeback,
  output logic [3:0]  cpsr_nzcv,
  output logic        done,
  output logic        done_illegal,
  output logic        done_cond_pass
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t      state;
  logic [31:0] ir;
  logic [3:0]  nzcv_q;
  logic        flag_upd;

  logic [3:0]  opcode;
  logic        set_flags;
  logic        is_test;
  logic        is_logic;
  logic        reg_bad;
  logic        illegal;
  logic        cond_pass;
  logic [31:0] op2;
  logic        sh_c;

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] s);
    return (v >> s) | (v << (6'd32 - {1'b0, s}));
  endfunction

  assign opcode    = ir[24:21];
  assign set_flags = ir[20];
  assign is_test   = (opcode[3:2] == 2'b10);
  assign is_logic  = (opcode[2:1] == 2'b00) || (opcode[3:2] == 2'b11);

  assign instr_ready   = reset && (state == S_IDLE);
  assign rf_raddr_a    = ir[19:16];
  assign rf_raddr_b    = ir[3:0];
  assign alu_control   = opcode;
  assign alu_carry     = cpsr_nzcv[1];
  assign alu_operand_a = (state == S_EXEC) ? rf_rdata_a : '0;
  assign alu_operand_b = (state == S_EXEC) ? op2 : '0;

`ifdef DP_SEQUENCER_SHIFT_EN
  assign reg_bad = !ir[25] && ir[4];
`else
  assign reg_bad = !ir[25] && (ir[11:4] != 8'h00);
`endif

  assign illegal = (ir[27:26] != 2'b00) || reg_bad || (is_test && !set_flags) ||
                   ((ir[15:12] == 4'hF) && !is_test);

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = cpsr_nzcv;
    cond_pass = 1'b0;
    case (ir[31:28])
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = !c;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = c && !z;
      4'h9: cond_pass = !c || z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = !z && (n == v);
      4'hD: cond_pass = z || (n != v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Shift amount 0 encodes LSR/ASR #32 and RRX; the 33-bit forms carry the shifted-out bit.
  always_comb begin
    op2  = '0;
    sh_c = cpsr_nzcv[1];
    if (ir[25]) begin
      op2 = ror32({24'h0, ir[7:0]}, {ir[11:8], 1'b0});
      if (ir[11:8] != 4'h0) sh_c = op2[31];
    end else begin
`ifdef DP_SEQUENCER_SHIFT_EN
      logic [4:0]  amt;
      logic [31:0] rm;
      amt = ir[11:7];
      rm  = rf_rdata_b;
      case (ir[6:5])
        2'b00: begin
          if (amt == 5'd0) op2 = rm;
          else {sh_c, op2} = {1'b0, rm} << amt;
        end
        2'b01: begin
          if (amt == 5'd0) begin
            op2  = '0;
            sh_c = rm[31];
          end else {op2, sh_c} = {rm, 1'b0} >> amt;
        end
        2'b10: begin
          if (amt == 5'd0) begin
            op2  = {32{rm[31]}};
            sh_c = rm[31];
          end else {op2, sh_c} = $signed({rm, 1'b0}) >>> amt;
        end
        default: begin
          if (amt == 5'd0) begin
            op2  = {cpsr_nzcv[1], rm[31:1]};
            sh_c = rm[0];
          end else begin
            op2  = ror32(rm, amt);
            sh_c = op2[31];
          end
        end
      endcase
`else
      op2 = rf_rdata_b;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      ir             <= '0;
      cpsr_nzcv      <= '0;
      nzcv_q         <= '0;
      flag_upd       <= 1'b0;
      rf_we          <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      done           <= 1'b0;
      done_illegal   <= 1'b0;
      done_cond_pass <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= S_READ;
          end
        end
        S_READ: state <= S_EXEC;
        S_EXEC: begin
          rf_we          <= !illegal && cond_pass && alu_result_writeback;
          rf_waddr       <= ir[15:12];
          rf_wdata       <= alu_result;
          done           <= 1'b1;
          done_illegal   <= illegal;
          done_cond_pass <= !illegal && cond_pass;
          flag_upd       <= !illegal && cond_pass && set_flags;
          // Logical ops take C from the shifter and keep V.
          nzcv_q         <= is_logic ? {alu_nzcv[3:2], sh_c, cpsr_nzcv[0]} : alu_nzcv;
          state          <= S_WB;
        end
        S_WB: begin
          if (flag_upd) cpsr_nzcv <= nzcv_q;
          flag_upd       <= 1'b0;
          rf_we          <= 1'b0;
          rf_waddr       <= '0;
          rf_wdata       <= '0;
          done           <= 1'b0;
          done_illegal   <= 1'b0;
          done_cond_pass <= 1'b0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer: register file and ALU environment, instruction-level reference model,
// per-cycle compare process, directed literal checks and randomized instruction stream.
module tb_dp_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid, instr_ready;
  logic [31:0] instr;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [31:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic [31:0] alu_operand_a, alu_operand_b, alu_result;
  logic [3:0]  alu_control, alu_nzcv, cpsr_nzcv;
  logic        alu_carry, alu_result_writeback;
  logic        done, done_illegal, done_cond_pass;

  always #5 clk = ~clk;

  dp_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_control(alu_control),
    .alu_carry(alu_carry), .alu_result(alu_result), .alu_nzcv(alu_nzcv),
    .alu_result_writeback(alu_result_writeback), .cpsr_nzcv(cpsr_nzcv),
    .done(done), .done_illegal(done_illegal), .done_cond_pass(done_cond_pass)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU: {writeback, nzcv, result}
  function automatic logic [36:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic c);
    logic [31:0] x, y, r;
    logic [32:0] s;
    logic cin, cf, vf, arith;
    arith = 1'b1; x = a; y = b; cin = 1'b0; r = '0;
    case (op)
      4'h2, 4'hA: begin y = ~b; cin = 1'b1; end
      4'h3:       begin x = b; y = ~a; cin = 1'b1; end
      4'h4, 4'hB: ;
      4'h5:       cin = c;
      4'h6:       begin y = ~b; cin = c; end
      4'h7:       begin x = b; y = ~a; cin = c; end
      default:    arith = 1'b0;
    endcase
    s  = {1'b0, x} + {1'b0, y} + {32'h0, cin};
    cf = c; vf = 1'b0;
    if (arith) begin
      r  = s[31:0];
      cf = s[32];
      vf = (x[31] == y[31]) && (r[31] != x[31]);
    end else begin
      case (op)
        4'h0, 4'h8: r = a & b;
        4'h1, 4'h9: r = a ^ b;
        4'hC:       r = a | b;
        4'hD:       r = b;
        4'hE:       r = a & ~b;
        default:    r = ~b;
      endcase
    end
    return {op[3:2] != 2'b10, r[31], r == 32'h0, cf, vf, r};
  endfunction

  always_comb {alu_result_writeback, alu_nzcv, alu_result} = alu_fn(alu_control, alu_operand_a, alu_operand_b, alu_carry);

  logic [31:0] rf [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    rf_rdata_a <= rf[rf_raddr_a];
    rf_rdata_b <= rf[rf_raddr_b];
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (pre_en) rf[pre_addr] <= pre_data;
  end

  typedef struct packed {
    logic        illegal;
    logic        pass;
    logic        we;
    logic [3:0]  op, rn, rm, rd;
    logic [31:0] opa, opb, res;
    logic [3:0]  nfl;
  } exp_t;

  logic [31:0] mrf [16];
  logic [3:0]  mfl;
  int          age;
  exp_t        cur;

  function automatic exp_t predict(input logic [31:0] i);
    exp_t e;
    logic n, z, cf, vf, base, c, legal;
    logic [31:0] v;
    logic [36:0] a;
    int lim;
    int unsigned amt;
    e = '0;
    {n, z, cf, vf} = mfl;
    e.op = i[24:21]; e.rn = i[19:16]; e.rd = i[15:12]; e.rm = i[3:0];
    case (i[31:29])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = vf;
      3'd4: base = cf && !z;
      3'd5: base = (n == vf);
      3'd6: base = !z && (n == vf);
      default: base = 1'b1;
    endcase
    e.pass = i[28] ? !base : base;
    if (i[31:28] == 4'hF) e.pass = 1'b0;
    e.illegal = (i[27:26] != 2'b00) || (i[24:23] == 2'b10 && !i[20]) ||
                (i[15:12] == 4'hF && i[24:23] != 2'b10);
    c = mfl[1];
    if (i[25]) begin
      v = {24'h0, i[7:0]};
      lim = 2 * int'(i[11:8]);
      for (int k = 0; k < lim; k++) v = {v[0], v[31:1]};
      if (i[11:8] != 4'h0) c = v[31];
    end else begin
      v = mrf[e.rm];
`ifdef DP_SEQUENCER_SHIFT_EN
      if (i[4]) e.illegal = 1'b1;
      amt = i[11:7];
      if (i[6:5] == 2'b11 && amt == 0) begin
        c = v[0];
        v = {mfl[1], v[31:1]};
      end else begin
        if (amt == 0 && i[6:5] != 2'b00) amt = 32;
        for (int unsigned k = 0; k < amt; k++) begin
          case (i[6:5])
            2'b00:   begin c = v[31]; v = v << 1; end
            2'b01:   begin c = v[0];  v = v >> 1; end
            2'b10:   begin c = v[0];  v = {v[31], v[31:1]}; end
            default: begin c = v[0];  v = {v[0], v[31:1]}; end
          endcase
        end
      end
`else
      if (i[11:4] != 8'h00) e.illegal = 1'b1;
`endif
    end
    a = alu_fn(e.op, mrf[e.rn], v, mfl[1]);
    e.opa = mrf[e.rn];
    e.opb = v;
    e.res = a[31:0];
    legal = !e.illegal && e.pass;
    e.we  = legal && a[36];
    e.nfl = mfl;
    if (legal && i[20]) begin
      if (e.op inside {4'h0, 4'h1, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF})
        e.nfl = {a[31], a[31:0] == 32'h0, c, mfl[0]};
      else
        e.nfl = a[35:32];
    end
    return e;
  endfunction

  // age: 0 idle, 1..3 cycles after the accepting edge
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      age = 0;
      mfl = 4'h0;
    end else begin
      if (pre_en) mrf[pre_addr] = pre_data;
      if (age == 0) begin
        if (instr_valid) begin
          cur = predict(instr);
          age = 1;
        end
      end else if (age == 3) begin
        if (cur.we) mrf[cur.rd] = cur.res;
        mfl = cur.nfl;
        age = 0;
      end else begin
        age++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_ctrl", 32'({instr_ready, rf_we, done, done_illegal, done_cond_pass, alu_carry,
                             rf_waddr, cpsr_nzcv, rf_raddr_a, rf_raddr_b, alu_control}), 32'h0);
      chk("reset_data", rf_wdata | alu_operand_a | alu_operand_b, 32'h0);
    end else begin
      chk("instr_ready", 32'(instr_ready), 32'(age == 0));
      chk("done", 32'(done), 32'(age == 3));
      chk("done_illegal", 32'(done_illegal), 32'(age == 3 && cur.illegal));
      chk("done_cond_pass", 32'(done_cond_pass), 32'(age == 3 && !cur.illegal && cur.pass));
      chk("rf_we", 32'(rf_we), 32'(age == 3 && cur.we));
      chk("cpsr_nzcv", 32'(cpsr_nzcv), 32'(mfl));
      chk("alu_carry", 32'(alu_carry), 32'(mfl[1]));
      if (age == 1) begin
        chk("rf_raddr_a", 32'(rf_raddr_a), 32'(cur.rn));
        chk("rf_raddr_b", 32'(rf_raddr_b), 32'(cur.rm));
      end
      if (age == 2) begin
        chk("alu_control", 32'(alu_control), 32'(cur.op));
        chk("alu_operand_a", alu_operand_a, cur.opa);
        if (!cur.illegal) chk("alu_operand_b", alu_operand_b, cur.opb);
      end
      if (age == 3 && cur.we) begin
        chk("rf_waddr", 32'(rf_waddr), 32'(cur.rd));
        chk("rf_wdata", rf_wdata, cur.res);
      end
    end
  end

  task automatic set_reg(input logic [3:0] r, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = r; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] w);
    for (int k = 0; k < 20 && !instr_ready; k++) @(negedge clk);
    if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 32'h1);
    instr_valid = 1'b1;
    instr = w;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = $urandom;
  endtask

  task automatic to_wb();
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(2) == 0) r[31:28] = 4'hE;
    if ($urandom_range(7) != 0) r[27:26] = 2'b00;
`ifdef DP_SEQUENCER_SHIFT_EN
    if (!r[25] && $urandom_range(7) != 0) r[4] = 1'b0;
`else
    if (!r[25] && $urandom_range(3) != 0) r[11:4] = 8'h00;
`endif
    return r;
  endfunction

  initial begin
    instr_valid = 1'b0;
    instr = '0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("ready_after_release", 32'(instr_ready), 32'h1);
    @(negedge clk);
    for (int r = 0; r < 16; r++) set_reg(4'(r), $urandom);

    set_reg(4'd2, 32'd3);
    issue(32'hE2921005);
    to_wb();
    chk("adds_we", 32'(rf_we), 32'h1);
    chk("adds_waddr", 32'(rf_waddr), 32'h1);
    chk("adds_wdata", rf_wdata, 32'd8);
    @(negedge clk);
    chk("adds_flags", 32'(cpsr_nzcv), 32'h0);

    set_reg(4'd0, 32'd7);
    issue(32'hE0500000);
    to_wb();
    chk("subs_wdata", rf_wdata, 32'h0);
    @(negedge clk);
    chk("subs_flags", 32'(cpsr_nzcv), 32'h6);
    issue(32'h12833001);
    to_wb();
    chk("addne_done", 32'(done), 32'h1);
    chk("addne_pass", 32'(done_cond_pass), 32'h0);
    chk("addne_we", 32'(rf_we), 32'h0);
    @(negedge clk);
    chk("addne_flags", 32'(cpsr_nzcv), 32'h6);

    issue(32'hE3B044FF);
    to_wb();
    chk("movs_wdata", rf_wdata, 32'hFF000000);
    chk("movs_waddr", 32'(rf_waddr), 32'h4);
    @(negedge clk);
    chk("movs_flags", 32'(cpsr_nzcv), 32'hA);

    issue(32'hE1400000);
    to_wb();
    chk("cmp_noS_illegal", 32'(done_illegal), 32'h1);
    chk("cmp_noS_we", 32'(rf_we), 32'h0);
    @(negedge clk);
    chk("cmp_noS_flags", 32'(cpsr_nzcv), 32'hA);

    set_reg(4'd1, 32'd10);
    set_reg(4'd2, 32'd20);
    issue(32'hE0811002);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("abort_flags", 32'(cpsr_nzcv), 32'h0);
    issue(32'hE0811002);
    to_wb();
    chk("after_abort_we", 32'(rf_we), 32'h1);
    chk("after_abort_wdata", rf_wdata, 32'd30);
    @(negedge clk);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      instr_valid = ($urandom_range(3) != 0);
      instr = gen();
      if (cyc == 1500) begin
        #1 reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
      end
    end
    instr_valid = 1'b0;
    repeat (6) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
